// File: rtl/cnt_pkg.sv
// Shared constants for the counter family: default width and legal width range.
package cnt_pkg;
    localparam int CNT_WIDTH_DEF = 4;
    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 8;

    function automatic bit cnt_width_ok(input int w);
        return (w >= CNT_WIDTH_MIN) && (w <= CNT_WIDTH_MAX);
    endfunction
endpackage

// File: rtl/tff_ar.sv
// T flip-flop with asynchronous active-low reset; toggles on a rising edge when t is high.
module tff_ar (
    input  logic clk,
    input  logic nrst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)  q <= 1'b0;
        else if (t) q <= ~q;
    end
endmodule

// File: rtl/downcnt_tff.sv
// Loadable down-counter built from T flip-flops, with wrap / stop-at-zero modes
// and a registered done pulse on a counted 1 -> 0 step.
module downcnt_tff
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             done
);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] bz;
    logic             cnt;

    if (!cnt_width_ok(WIDTH)) begin : g_bad_width
        $error("downcnt_tff: WIDTH out of range");
    end

    assign zero = (q == '0);
    // A counted edge: enabled, not overridden by load, not parked at zero in one-shot mode.
    assign cnt  = en & ~load & ~(oneshot & zero);

    // bz[i] is high when every bit below i is zero, i.e. a borrow reaches bit i.
    assign bz[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign bz[i] = bz[i-1] & ~q[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign t[i] = load ? (q[i] ^ d[i]) : (cnt & bz[i]);
        tff_ar u_tff (
            .clk  (clk),
            .nrst (nrst),
            .t    (t[i]),
            .q    (q[i])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) done <= 1'b0;
        else       done <= cnt & (q == WIDTH'(1));
    end
endmodule

// File: tb/tb_downcnt_tff.sv
// Directed table-driven bench for downcnt_tff at WIDTH = 4, plus reset and hold sequences.
module tb_downcnt_tff;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic       oneshot = 1'b0;
    logic [3:0] q;
    logic       zero;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       ld;
        logic       en;
        logic       os;
        logic [3:0] d;
        logic [3:0] eq;
        logic       edone;
    } vec_t;

    vec_t vt[$];

    downcnt_tff #(.WIDTH(4)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .en      (en),
        .load    (load),
        .d       (d),
        .oneshot (oneshot),
        .q       (q),
        .zero    (zero),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] eq, input logic edone);
        chk({name, ".q"}, int'(q), int'(eq));
        chk({name, ".zero"}, int'(zero), int'(eq == 4'd0));
        chk({name, ".done"}, int'(done), int'(edone));
    endtask

    task automatic add(input string n, input logic ld, input logic e, input logic os,
                       input logic [3:0] dv, input logic [3:0] eq, input logic ed);
        vec_t v;
        v.name = n; v.ld = ld; v.en = e; v.os = os; v.d = dv; v.eq = eq; v.edone = ed;
        vt.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic e, input logic os, input logic [3:0] dv);
        load = ld; en = e; oneshot = os; d = dv;
    endtask

    initial begin
        //   name        ld en os d   q   done
        add("ld2",       1, 0, 0, 2,  2,  0);
        add("wrap1",     0, 1, 0, 0,  1,  0);
        add("wrap0",     0, 1, 0, 0,  0,  1);
        add("wrap15",    0, 1, 0, 0,  15, 0);
        add("wrap14",    0, 1, 0, 0,  14, 0);
        add("ld3",       1, 0, 1, 3,  3,  0);
        add("os2",       0, 1, 1, 0,  2,  0);
        add("os1",       0, 1, 1, 0,  1,  0);
        add("os0",       0, 1, 1, 0,  0,  1);
        add("oshold_a",  0, 1, 1, 0,  0,  0);
        add("oshold_b",  0, 1, 1, 0,  0,  0);
        add("oshold_c",  0, 1, 1, 0,  0,  0);
        add("mode_sw",   0, 1, 0, 0,  15, 0);
        add("ld9",       1, 0, 0, 9,  9,  0);
        add("ldprio",    1, 1, 0, 5,  5,  0);
        add("ld1",       1, 0, 0, 1,  1,  0);
        add("ld0_nodn",  1, 1, 1, 0,  0,  0);
        add("ld7",       1, 0, 0, 7,  7,  0);

        // reset state, no clock edge needed
        #2;
        chk_all("reset", 4'd0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].ld, vt[i].en, vt[i].os, vt[i].d);
            step();
            chk_all(vt[i].name, vt[i].eq, vt[i].edone);
        end

        // hold at 7 for 10 edges
        drive(0, 0, 0, 4'd3);
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all("hold", 4'd7, 1'b0);
        end

        // asynchronous reset from an arbitrary value
        drive(1, 0, 0, 4'd11);
        step();
        chk_all("ld11", 4'd11, 1'b0);
        drive(0, 0, 0, 4'd0);
        #2 nrst = 1'b0;
        #1 chk_all("async_rst", 4'd0, 1'b0);
        #1 nrst = 1'b1;

        // reset while done is high clears it immediately
        drive(1, 0, 0, 4'd1);
        step();
        drive(0, 1, 0, 4'd0);
        step();
        chk_all("dn_pulse", 4'd0, 1'b1);
        #1 nrst = 1'b0;
        #1 chk_all("rst_dn", 4'd0, 1'b0);
        #1 nrst = 1'b1;

        // reset mid-count at q = 1: no done after release
        drive(1, 0, 0, 4'd1);
        step();
        chk_all("mid_ld1", 4'd1, 1'b0);
        drive(0, 1, 0, 4'd0);
        #2 nrst = 1'b0;
        #1 chk_all("mid_rst", 4'd0, 1'b0);
        #1 nrst = 1'b1;
        step();
        chk_all("mid_after", 4'd15, 1'b0);
        step();
        chk_all("mid_after2", 4'd14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/downcnt_tff.md
DOWNCNT_TFF -- requirements
Module: downcnt_tff

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  count enable; decrement by one when high.
REQ-005 SHALL have port load  input  1  synchronous parallel load of d.
REQ-006 SHALL have port d  input  WIDTH  load value.
REQ-007 SHALL have port oneshot  input  1  mode select: 0 = wrap, 1 = stop at zero.
REQ-008 SHALL have port q  output  WIDTH  current count.
REQ-009 SHALL have port zero  output  1  combinational flag, high when q == 0.
REQ-010 SHALL have port done  output  1  registered one-cycle pulse on a counted 1 -> 0 transition.

Function
REQ-011 SHALL implement state as WIDTH T flip-flops; every bit SHALL change only through its T input.
REQ-012 SHALL, while counting, drive T[0] = 1 and T[i] = 1 only when all bits q[i-1:0] are 0 (borrow chain), gated by the count condition.
REQ-013 SHALL, when load = 1, drive T[i] = q[i] XOR d[i], so that q = d after the edge.
REQ-014 SHALL give load priority over en; en is ignored in a load cycle.
REQ-015 SHALL hold q when load = 0 and en = 0 (all T = 0).
REQ-016 SHALL, in wrap mode (oneshot = 0), decrement 0 -> 2^WIDTH-1 on an enabled edge.
REQ-017 SHALL, in one-shot mode (oneshot = 1), hold q at 0 when en = 1 and q == 0 (all T = 0).
REQ-018 SHALL assert done for exactly the cycle after an enabled edge takes q from 1 to 0, in either mode.
REQ-019 SHALL NOT assert done on a load of 0, on the 0 -> max wrap, or while q is held at 0.
REQ-020 SHALL sample oneshot each cycle; a change takes effect on the next edge with no other side effects.
REQ-021 SHALL have zero latency on the zero flag (combinational from q) and one-cycle latency on done.

Reset
REQ-022 SHALL, while nrst = 0, force q = 0 and done = 0 asynchronously, independent of clk.
REQ-023 SHALL drive zero = 1 during reset, because it follows q.
REQ-024 SHALL, on reset assertion mid-count or mid-load, abandon the operation; no done pulse follows the release.
REQ-025 SHALL resume normal behaviour on the first rising clk edge after nrst deasserts.

Structure
REQ-026 SHALL place the WIDTH default and the WIDTH legal-range bounds in a shared package, cnt_pkg.
REQ-027 SHALL use one sub-module, tff_ar: a T flip-flop with async active-low reset, ports q, t, clk, nrst, instantiated WIDTH times via generate.
REQ-028 SHALL keep the T-input logic (borrow chain, load XOR, one-shot hold) in downcnt_tff, outside tff_ar.
REQ-029 SHALL be free of latches and combinational loops.

Verification
REQ-030 SHALL check reset: nrst = 0 at an arbitrary q -> q = 0, zero = 1, done = 0 immediately, with no clk edge needed.
REQ-031 SHALL check wrap: WIDTH = 4, oneshot = 0, en = 1 from q = 2 for 4 edges -> q = 1, 0, 15, 14; done high only in the cycle after 1 -> 0.
REQ-032 SHALL check one-shot: load d = 3, then en = 1, oneshot = 1 for 6 edges -> q = 2, 1, 0, 0, 0, 0; exactly one done pulse.
REQ-033 SHALL check load priority: q = 9, load = 1, en = 1, d = 5 -> q = 5 after the edge, not 8 or 4.
REQ-034 SHALL check hold: en = 0, load = 0 for 10 edges at q = 7 -> q stays 7, done stays 0.
REQ-035 SHALL check reset mid-count: q = 1, en = 1, nrst pulsed low between edges -> q = 0, and no done pulse after release.
